// File: rtl/mc_sequencer.sv
// Multicycle RV32I instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory timeouts.
// Optional performance counters are enabled by defining MC_SEQ_PERF_CNT_EN.
module mc_sequencer #(
  parameter int unsigned MAX_WAIT = 16
`ifdef MC_SEQ_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W    = 32
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic [6:0] op_code_i,
  input  logic       branch_taken_i,
  input  logic       imem_ready_i,
  input  logic       dmem_ready_i,
  output logic       imem_req_o,
  output logic       ir_write_en_o,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  output logic       mdr_write_en_o,
  output logic       rf_write_en_o,
  output logic       pc_write_en_o,
  output logic [1:0] pc_sel_o,
  output logic       instr_done_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o,
  output logic [2:0] state_o
`ifdef MC_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o
`endif
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    TRAP    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM    = 2'd2,
    CAUSE_DMEM    = 2'd3
  } cause_t;

  state_t            state_q, state_n;
  cause_t            cause_q, cause_n;
  logic [WAIT_W-1:0] wait_q;
  logic              wait_expired;
  logic              is_load, is_store, is_branch, is_jal, is_jalr, op_valid;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    op_valid  = 1'b1;
    case (op_code_i)
      7'b0000011: is_load   = 1'b1;
      7'b0100011: is_store  = 1'b1;
      7'b1100011: is_branch = 1'b1;
      7'b1101111: is_jal    = 1'b1;
      7'b1100111: is_jalr   = 1'b1;
      7'b0010011, 7'b0010111, 7'b0110111, 7'b0110011: op_valid = 1'b1;
      default:    op_valid  = 1'b0;
    endcase
  end

  assign wait_expired = (wait_q == WAIT_LAST);

  // Counter restarts whenever the state changes, so each FETCH/MEM entry gets the full budget.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_n;
      cause_q <= cause_n;
      if (state_n != state_q) begin
        wait_q <= '0;
      end else if ((state_q == FETCH || state_q == MEM) && !wait_expired) begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_n        = state_q;
    cause_n        = cause_q;
    imem_req_o     = 1'b0;
    ir_write_en_o  = 1'b0;
    dmem_req_o     = 1'b0;
    dmem_we_o      = 1'b0;
    mdr_write_en_o = 1'b0;
    rf_write_en_o  = 1'b0;
    pc_write_en_o  = 1'b0;
    pc_sel_o       = 2'd0;
    instr_done_o   = 1'b0;
    trap_o         = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_i) state_n = FETCH;
      end
      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_write_en_o = 1'b1;
          state_n       = DECODE;
        end else if (wait_expired) begin
          state_n = TRAP;
          cause_n = CAUSE_IMEM;
        end
      end
      DECODE: begin
        if (!op_valid) begin
          state_n = TRAP;
          cause_n = CAUSE_ILLEGAL;
        end else begin
          state_n = EXECUTE;
        end
      end
      EXECUTE: begin
        if (is_load || is_store) begin
          state_n = MEM;
        end else if (is_branch) begin
          pc_write_en_o = 1'b1;
          pc_sel_o      = branch_taken_i ? 2'd1 : 2'd0;
          instr_done_o  = 1'b1;
          state_n       = run_i ? FETCH : IDLE;
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store;
        if (dmem_ready_i) begin
          if (is_store) begin
            pc_write_en_o = 1'b1;
            instr_done_o  = 1'b1;
            state_n       = run_i ? FETCH : IDLE;
          end else begin
            mdr_write_en_o = 1'b1;
            state_n        = WB;
          end
        end else if (wait_expired) begin
          state_n = TRAP;
          cause_n = CAUSE_DMEM;
        end
      end
      WB: begin
        rf_write_en_o = 1'b1;
        pc_write_en_o = 1'b1;
        instr_done_o  = 1'b1;
        pc_sel_o      = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        state_n       = run_i ? FETCH : IDLE;
      end
      TRAP: begin
        trap_o = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign trap_cause_o = cause_q;
  assign state_o      = state_q;

`ifdef MC_SEQ_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_o   <= '0;
      instret_cnt_o <= '0;
    end else begin
      if (state_q != IDLE && state_q != TRAP) cycle_cnt_o <= cycle_cnt_o + 1'b1;
      if (instr_done_o) instret_cnt_o <= instret_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed, table-driven bench for mc_sequencer: one record per clock cycle of inputs
// and the state/strobes expected during that cycle.
module tb_mc_sequencer;

  localparam int MW = 16;

  logic       clk_i = 1'b0;
  logic       rst_i, run_i, branch_taken_i, imem_ready_i, dmem_ready_i;
  logic [6:0] op_code_i;
  logic       imem_req_o, ir_write_en_o, dmem_req_o, dmem_we_o, mdr_write_en_o;
  logic       rf_write_en_o, pc_write_en_o, instr_done_o, trap_o;
  logic [1:0] pc_sel_o, trap_cause_o;
  logic [2:0] state_o;

  mc_sequencer #(.MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .op_code_i(op_code_i),
    .branch_taken_i(branch_taken_i), .imem_ready_i(imem_ready_i),
    .dmem_ready_i(dmem_ready_i), .imem_req_o(imem_req_o),
    .ir_write_en_o(ir_write_en_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .mdr_write_en_o(mdr_write_en_o), .rf_write_en_o(rf_write_en_o),
    .pc_write_en_o(pc_write_en_o), .pc_sel_o(pc_sel_o), .instr_done_o(instr_done_o),
    .trap_o(trap_o), .trap_cause_o(trap_cause_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst, run;
    logic [6:0] op;
    logic       tk, ir, dr;
    logic [2:0] st;
    logic [12:0] o;
  } vec_t;

  localparam logic [6:0] ALU  = 7'b0110011, BR  = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, ST  = 7'b0100011, LD  = 7'b0000011;
  localparam logic [6:0] LUI  = 7'b0110111, BAD = 7'b1111111;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int row       = 0;
  vec_t tbl[$];

  logic [12:0] N, FQ, FA, WB0, WB1, WB2, BRT, BRN, SW, SD, LW, LDN, TR1, TR2, TR3;

  // Output bundle order: imem_req, ir_we, dmem_req, dmem_we, mdr_we, rf_we, pc_we, pc_sel, done, trap, cause
  function automatic logic [12:0] ob(input logic imem, irw, dreq, dwe, mdr, rf, pcw,
                                     input logic [1:0] sel, input logic done, trp,
                                     input logic [1:0] cause);
    return {imem, irw, dreq, dwe, mdr, rf, pcw, sel, done, trp, cause};
  endfunction

  function automatic vec_t mk(input logic rst, run, input logic [6:0] op,
                              input logic tk, ir, dr, input logic [2:0] st,
                              input logic [12:0] o);
    vec_t v;
    v.rst = rst; v.run = run; v.op = op; v.tk = tk; v.ir = ir; v.dr = dr;
    v.st = st; v.o = o;
    return v;
  endfunction

  task automatic cyc(input vec_t v);
    logic [12:0] act;
    @(negedge clk_i);
    rst_i = v.rst; run_i = v.run; op_code_i = v.op;
    branch_taken_i = v.tk; imem_ready_i = v.ir; dmem_ready_i = v.dr;
    #1;
    act = {imem_req_o, ir_write_en_o, dmem_req_o, dmem_we_o, mdr_write_en_o,
           rf_write_en_o, pc_write_en_o, pc_sel_o, instr_done_o, trap_o, trap_cause_o};
    total_cnt++;
    if (state_o === v.st) pass_cnt++;
    else $display("FAIL state row %0d: got %0d want %0d", row, state_o, v.st);
    total_cnt++;
    if (act === v.o) pass_cnt++;
    else $display("FAIL outputs row %0d: got %b want %b", row, act, v.o);
    row++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    N   = ob(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    FQ  = ob(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    FA  = ob(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    WB0 = ob(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0);
    WB1 = ob(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0);
    WB2 = ob(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0);
    BRT = ob(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0);
    BRN = ob(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0);
    SW  = ob(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    SD  = ob(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0);
    LW  = ob(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    LDN = ob(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    TR1 = ob(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1);
    TR2 = ob(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2);
    TR3 = ob(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3);

    // Zero-wait instruction mix, then a load with 3 wait cycles while run drops.
    tbl.push_back(mk(1'b0, 1'b0, ALU, 1'b0, 1'b0, 1'b0, 3'd0, N));
    tbl.push_back(mk(1'b0, 1'b1, ALU, 1'b0, 1'b1, 1'b0, 3'd0, N));
    tbl.push_back(mk(1'b0, 1'b1, ALU, 1'b0, 1'b1, 1'b0, 3'd1, FA));
    tbl.push_back(mk(1'b0, 1'b1, ALU, 1'b0, 1'b0, 1'b0, 3'd2, N));
    tbl.push_back(mk(1'b0, 1'b1, ALU, 1'b1, 1'b0, 1'b0, 3'd3, N));
    tbl.push_back(mk(1'b0, 1'b1, ALU, 1'b0, 1'b0, 1'b0, 3'd5, WB0));
    tbl.push_back(mk(1'b0, 1'b1, BR,  1'b0, 1'b1, 1'b0, 3'd1, FA));
    tbl.push_back(mk(1'b0, 1'b1, BR,  1'b0, 1'b0, 1'b0, 3'd2, N));
    tbl.push_back(mk(1'b0, 1'b1, BR,  1'b1, 1'b0, 1'b0, 3'd3, BRT));
    tbl.push_back(mk(1'b0, 1'b1, BR,  1'b0, 1'b1, 1'b0, 3'd1, FA));
    tbl.push_back(mk(1'b0, 1'b1, BR,  1'b0, 1'b0, 1'b0, 3'd2, N));
    tbl.push_back(mk(1'b0, 1'b1, BR,  1'b0, 1'b0, 1'b0, 3'd3, BRN));
    tbl.push_back(mk(1'b0, 1'b1, JAL, 1'b0, 1'b1, 1'b0, 3'd1, FA));
    tbl.push_back(mk(1'b0, 1'b1, JAL, 1'b0, 1'b0, 1'b0, 3'd2, N));
    tbl.push_back(mk(1'b0, 1'b1, JAL, 1'b0, 1'b0, 1'b0, 3'd3, N));
    tbl.push_back(mk(1'b0, 1'b1, JAL, 1'b0, 1'b0, 1'b0, 3'd5, WB1));
    tbl.push_back(mk(1'b0, 1'b1, JALR, 1'b0, 1'b1, 1'b0, 3'd1, FA));
    tbl.push_back(mk(1'b0, 1'b1, JALR, 1'b0, 1'b0, 1'b0, 3'd2, N));
    tbl.push_back(mk(1'b0, 1'b1, JALR, 1'b0, 1'b0, 1'b0, 3'd3, N));
    tbl.push_back(mk(1'b0, 1'b1, JALR, 1'b0, 1'b0, 1'b0, 3'd5, WB2));
    tbl.push_back(mk(1'b0, 1'b1, LUI, 1'b0, 1'b1, 1'b0, 3'd1, FA));
    tbl.push_back(mk(1'b0, 1'b1, LUI, 1'b0, 1'b0, 1'b0, 3'd2, N));
    tbl.push_back(mk(1'b0, 1'b1, LUI, 1'b0, 1'b0, 1'b0, 3'd3, N));
    tbl.push_back(mk(1'b0, 1'b1, LUI, 1'b0, 1'b0, 1'b0, 3'd5, WB0));
    tbl.push_back(mk(1'b0, 1'b1, ST,  1'b0, 1'b1, 1'b0, 3'd1, FA));
    tbl.push_back(mk(1'b0, 1'b1, ST,  1'b0, 1'b0, 1'b0, 3'd2, N));
    tbl.push_back(mk(1'b0, 1'b1, ST,  1'b0, 1'b0, 1'b0, 3'd3, N));
    tbl.push_back(mk(1'b0, 1'b1, ST,  1'b0, 1'b0, 1'b1, 3'd4, SD));
    tbl.push_back(mk(1'b0, 1'b1, LD,  1'b0, 1'b1, 1'b0, 3'd1, FA));
    tbl.push_back(mk(1'b0, 1'b0, LD,  1'b0, 1'b0, 1'b0, 3'd2, N));
    tbl.push_back(mk(1'b0, 1'b0, LD,  1'b0, 1'b0, 1'b0, 3'd3, N));
    tbl.push_back(mk(1'b0, 1'b0, LD,  1'b0, 1'b0, 1'b0, 3'd4, LW));
    tbl.push_back(mk(1'b0, 1'b0, LD,  1'b0, 1'b0, 1'b0, 3'd4, LW));
    tbl.push_back(mk(1'b0, 1'b0, LD,  1'b0, 1'b0, 1'b0, 3'd4, LW));
    tbl.push_back(mk(1'b0, 1'b0, LD,  1'b0, 1'b0, 1'b1, 3'd4, LDN));
    tbl.push_back(mk(1'b0, 1'b0, LD,  1'b0, 1'b0, 1'b0, 3'd5, WB0));
    tbl.push_back(mk(1'b0, 1'b0, LD,  1'b0, 1'b0, 1'b0, 3'd0, N));
    tbl.push_back(mk(1'b0, 1'b0, LD,  1'b0, 1'b0, 1'b0, 3'd0, N));

    rst_i = 1'b1; run_i = 1'b0; op_code_i = ALU;
    branch_taken_i = 1'b0; imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);

    foreach (tbl[k]) cyc(tbl[k]);

    // Illegal opcode: trap sticks for 20 cycles regardless of run/ready, reset clears it.
    cyc(mk(1'b0, 1'b1, BAD, 1'b0, 1'b1, 1'b0, 3'd0, N));
    cyc(mk(1'b0, 1'b1, BAD, 1'b0, 1'b1, 1'b0, 3'd1, FA));
    cyc(mk(1'b0, 1'b1, BAD, 1'b0, 1'b0, 1'b0, 3'd2, N));
    for (int i = 0; i < 20; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      cyc(mk(1'b0, iv[0], BAD, 1'b0, 1'b1, 1'b1, 3'd7, TR1));
    end
    cyc(mk(1'b1, 1'b1, BAD, 1'b0, 1'b0, 1'b0, 3'd7, TR1));
    cyc(mk(1'b0, 1'b0, ALU, 1'b0, 1'b0, 1'b0, 3'd0, N));

    // IMEM never ready: exactly MW fetch cycles, then trap with cause 2.
    cyc(mk(1'b0, 1'b1, ALU, 1'b0, 1'b0, 1'b0, 3'd0, N));
    for (int i = 0; i < MW; i++) cyc(mk(1'b0, 1'b1, ALU, 1'b0, 1'b0, 1'b0, 3'd1, FQ));
    cyc(mk(1'b0, 1'b1, ALU, 1'b0, 1'b0, 1'b0, 3'd7, TR2));
    cyc(mk(1'b1, 1'b1, ALU, 1'b0, 1'b0, 1'b0, 3'd7, TR2));
    cyc(mk(1'b0, 1'b0, ALU, 1'b0, 1'b0, 1'b0, 3'd0, N));

    // Ready arriving on the last allowed fetch cycle is a success.
    cyc(mk(1'b0, 1'b1, ALU, 1'b0, 1'b0, 1'b0, 3'd0, N));
    for (int i = 0; i < MW - 1; i++) cyc(mk(1'b0, 1'b1, ALU, 1'b0, 1'b0, 1'b0, 3'd1, FQ));
    cyc(mk(1'b0, 1'b1, ALU, 1'b0, 1'b1, 1'b0, 3'd1, FA));
    cyc(mk(1'b0, 1'b1, ALU, 1'b0, 1'b0, 1'b0, 3'd2, N));
    cyc(mk(1'b0, 1'b1, ALU, 1'b0, 1'b0, 1'b0, 3'd3, N));
    cyc(mk(1'b0, 1'b0, ALU, 1'b0, 1'b0, 1'b0, 3'd5, WB0));
    cyc(mk(1'b0, 1'b0, ALU, 1'b0, 1'b0, 1'b0, 3'd0, N));

    // Store after a slow fetch: MEM gets a fresh MW-cycle budget, then traps with cause 3.
    cyc(mk(1'b0, 1'b1, ST, 1'b0, 1'b0, 1'b0, 3'd0, N));
    for (int i = 0; i < 5; i++) cyc(mk(1'b0, 1'b1, ST, 1'b0, 1'b0, 1'b0, 3'd1, FQ));
    cyc(mk(1'b0, 1'b1, ST, 1'b0, 1'b1, 1'b0, 3'd1, FA));
    cyc(mk(1'b0, 1'b1, ST, 1'b0, 1'b0, 1'b0, 3'd2, N));
    cyc(mk(1'b0, 1'b1, ST, 1'b0, 1'b0, 1'b0, 3'd3, N));
    for (int i = 0; i < MW; i++) cyc(mk(1'b0, 1'b1, ST, 1'b0, 1'b0, 1'b0, 3'd4, SW));
    cyc(mk(1'b0, 1'b1, ST, 1'b0, 1'b0, 1'b1, 3'd7, TR3));
    cyc(mk(1'b1, 1'b1, ST, 1'b0, 1'b0, 1'b0, 3'd7, TR3));
    cyc(mk(1'b0, 1'b0, ST, 1'b0, 1'b0, 1'b0, 3'd0, N));

    // Reset while a load waits in MEM: idle with all outputs low next cycle, then restart.
    cyc(mk(1'b0, 1'b1, LD, 1'b0, 1'b0, 1'b0, 3'd0, N));
    cyc(mk(1'b0, 1'b1, LD, 1'b0, 1'b1, 1'b0, 3'd1, FA));
    cyc(mk(1'b0, 1'b1, LD, 1'b0, 1'b0, 1'b0, 3'd2, N));
    cyc(mk(1'b0, 1'b1, LD, 1'b0, 1'b0, 1'b0, 3'd3, N));
    cyc(mk(1'b0, 1'b1, LD, 1'b0, 1'b0, 1'b0, 3'd4, LW));
    cyc(mk(1'b1, 1'b1, LD, 1'b0, 1'b0, 1'b0, 3'd4, LW));
    cyc(mk(1'b0, 1'b0, LD, 1'b0, 1'b0, 1'b1, 3'd0, N));
    cyc(mk(1'b0, 1'b1, LD, 1'b0, 1'b0, 1'b0, 3'd0, N));
    cyc(mk(1'b0, 1'b1, LD, 1'b0, 1'b1, 1'b0, 3'd1, FA));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Main state machine of the RV32I multicycle core.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB.
- Handshakes with instruction and data memory, and qualifies register-file, memory and PC write enables per state.
- Sits beside the combinational decoder: takes the opcode and branch outcome, drives datapath strobes, and traps on illegal opcodes or memory timeouts.

Parameters:
- MAX_WAIT, 16, cycles a memory request may wait for ready before trapping (>=2).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- run_i  in  1  run enable, sampled only at instruction boundaries
- op_code_i  in  7  opcode field from the instruction register
- branch_taken_i  in  1  ALU compare result, valid in EXECUTE
- imem_ready_i  in  1  instruction memory read data valid
- dmem_ready_i  in  1  data memory access complete
- imem_req_o  out  1  instruction fetch request
- ir_write_en_o  out  1  latch fetched word into IR
- dmem_req_o  out  1  data memory request
- dmem_we_o  out  1  data memory write (store)
- mdr_write_en_o  out  1  latch load data
- rf_write_en_o  out  1  register file write strobe
- pc_write_en_o  out  1  PC update strobe
- pc_sel_o  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = rs1+imm (JALR)
- instr_done_o  out  1  one-cycle retire pulse
- trap_o  out  1  core halted on a fault
- trap_cause_o  out  2  0 = none, 1 = illegal opcode, 2 = IMEM timeout, 3 = DMEM timeout
- state_o  out  3  current state, for debug

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0; wait counter 0; trap_cause_o 0.
  - Reset asserted in any state, including TRAP or mid-wait, aborts immediately to IDLE on the next edge.
  - No strobe may be asserted in the cycle after reset.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, TRAP=7.
- IDLE: all strobes 0. Goes to FETCH when run_i=1.
- FETCH:
  - imem_req_o=1 every cycle while in state.
  - On imem_ready_i: ir_write_en_o=1 for that cycle, then go to DECODE.
  - Otherwise the wait counter increments. When ready has not arrived within MAX_WAIT cycles of FETCH entry, go to TRAP with cause 2.
  - Ready in the same cycle the counter expires counts as success.
- DECODE: one cycle. Valid opcodes: 0000011, 0010011, 0010111, 0100011, 0110111, 0110011, 1100011, 1100111, 1101111. Any other opcode goes to TRAP with cause 1; otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - Load or store: go to MEM.
  - Branch (1100011): pc_write_en_o=1, pc_sel_o = branch_taken_i ? 1 : 0, instr_done_o=1; instruction ends.
  - All other opcodes: go to WB.
- MEM:
  - dmem_req_o=1; dmem_we_o=1 for store. Wait counter and timeout work as in FETCH, with cause 3.
  - On dmem_ready_i, store: pc_write_en_o=1, pc_sel_o=0, instr_done_o=1; instruction ends.
  - On dmem_ready_i, load: mdr_write_en_o=1, then go to WB.
- WB: one cycle.
  - rf_write_en_o=1, pc_write_en_o=1, instr_done_o=1.
  - pc_sel_o = 1 for JAL, 2 for JALR, else 0.
  - Instruction ends.
- Instruction end: next state is FETCH if run_i=1, else IDLE.
- Wait counter: cleared on every entry to FETCH or MEM; saturates and never wraps.
- TRAP:
  - trap_o=1, cause held, all strobes 0.
  - Exit only by reset; run_i is ignored.
- CPI with zero-wait memories (ready in the first request cycle): branch 3, store 4, ALU/LUI/AUIPC/JAL/JALR 4, load 5.
- pc_sel_o is 0 whenever pc_write_en_o=0.

Optional Feature:
- Macro: MC_SEQ_PERF_CNT_EN.
- When defined, adds two outputs:
  - cycle_cnt_o[CNT_W-1:0]: increments every cycle not in IDLE or TRAP.
  - instret_cnt_o[CNT_W-1:0]: increments on each instr_done_o.
- Both counters clear on reset and wrap at 2^CNT_W.
- When not defined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, run_i=1, zero-wait memories, opcode 0110011 -> state sequence 0,1,2,3,5,1; rf_write_en_o and instr_done_o high only in WB; pc_sel_o=0.
- Load (0000011), dmem_ready_i delayed 3 cycles -> dmem_req_o high 4 cycles, mdr_write_en_o pulses once, then WB; 8 cycles from FETCH entry to retire.
- Branch (1100011) with branch_taken_i=1 -> retires from EXECUTE, pc_sel_o=1, pc_write_en_o=1, rf_write_en_o never asserted; 3 cycles.
- Opcode 1111111 -> TRAP after DECODE, trap_o=1, trap_cause_o=1; stays in TRAP for 20 cycles with run_i toggling; reset returns state_o to 0.
- imem_ready_i held low -> TRAP with cause 2 exactly MAX_WAIT(16) cycles after FETCH entry; repeat with ready arriving on cycle 16 -> no trap.
- run_i dropped mid-instruction, then rst_i pulsed in MEM -> current instruction completes and goes to IDLE; reset mid-MEM gives all outputs 0 the next cycle.
